// File: rtl/mem_stage_pkg.sv
// Shared pipeline package: inter-stage bus widths, field offsets and layouts.
package mem_stage_pkg;

   localparam int DATA_W       = 32;
   localparam int EX_MEM_BUS_W = 124;
   localparam int MEM_WB_BUS_W = 118;
   localparam int MEM_ID_BUS_W = 38;

   // EX->MEM bus field offsets (LSB of each field)
   localparam int EM_PC_LSB      = 92;
   localparam int EM_RES_MEM_BIT = 91;
   localparam int EM_RF_WE_BIT   = 90;
   localparam int EM_WADDR_LSB   = 85;
   localparam int EM_ALU_LSB     = 53;
   localparam int EM_RKD_LSB     = 21;
   localparam int EM_ADDR_LSB    = 19;
   localparam int EM_OP_B_BIT    = 18;
   localparam int EM_OP_H_BIT    = 17;
   localparam int EM_OP_U_BIT    = 16;
   localparam int EM_CSR_RE_BIT  = 15;
   localparam int EM_CSR_WE_BIT  = 14;
   localparam int EM_CSR_NUM_LSB = 0;

   // MEM->WB bus field offsets
   localparam int MW_PC_LSB      = 86;
   localparam int MW_RF_WE_BIT   = 85;
   localparam int MW_WADDR_LSB   = 80;
   localparam int MW_RESULT_LSB  = 48;
   localparam int MW_RKD_LSB     = 16;
   localparam int MW_CSR_RE_BIT  = 15;
   localparam int MW_CSR_WE_BIT  = 14;
   localparam int MW_CSR_NUM_LSB = 0;

   // MEM->ID forwarding bus field offsets
   localparam int MI_RF_WE_BIT  = 37;
   localparam int MI_WADDR_LSB  = 32;
   localparam int MI_RESULT_LSB = 0;

   // Packed layouts, first member is the MSB field
   typedef struct packed {
      logic [31:0] pc;
      logic        res_from_mem;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] alu_result;
      logic [31:0] rkd_value;
      logic [1:0]  addr_low;
      logic        op_b;
      logic        op_h;
      logic        op_u;
      logic        csr_re;
      logic        csr_we;
      logic [13:0] csr_num;
   } ex_mem_bus_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] final_result;
      logic [31:0] rkd_value;
      logic        csr_re;
      logic        csr_we;
      logic [13:0] csr_num;
   } mem_wb_bus_t;

   typedef struct packed {
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] final_result;
   } mem_id_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: picks byte/halfword/word from the read word and extends it.
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [DATA_W-1:0] raw_rdata,
   input  logic [1:0]        addr_low,
   input  logic              op_b,
   input  logic              op_h,
   input  logic              op_u,
   output logic [DATA_W-1:0] data
);

   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;

   // Lane select plus sign/zero extension
   always_comb begin
      byte_s = '0;
      half_s = '0;
      data   = raw_rdata;
      case (addr_low)
         2'd0:    byte_s = raw_rdata[7:0];
         2'd1:    byte_s = raw_rdata[15:8];
         2'd2:    byte_s = raw_rdata[23:16];
         default: byte_s = raw_rdata[31:24];
      endcase
      half_s = addr_low[1] ? raw_rdata[31:16] : raw_rdata[15:0];
      if (op_b) begin
         data = op_u ? {24'b0, byte_s} : DATA_W'(byte_s);
      end else if (op_h) begin
         data = op_u ? {16'b0, half_s} : DATA_W'(half_s);
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, aligns load data and keeps the
// SRAM read word in a buffer while WB stalls so the result stays stable.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ex_to_mem_valid,
   input  logic [EX_MEM_BUS_W-1:0] ex_to_mem_bus,
   output logic                    mem_allowin,
   input  logic [DATA_W-1:0]       data_sram_rdata,
   input  logic                    wb_allowin,
   output logic                    mem_to_wb_valid,
   output logic [MEM_WB_BUS_W-1:0] mem_to_wb_bus,
   output logic [MEM_ID_BUS_W-1:0] mem_to_id_bus
);

   ex_mem_bus_t        ex_in;
   ex_mem_bus_t        payload_q, payload_d;
   logic               mem_valid_q, mem_valid_d;
   logic               first_cycle_q, first_cycle_d;
   logic               buf_valid_q, buf_valid_d;
   logic [DATA_W-1:0]  rdata_buf_q, rdata_buf_d;
   logic               mem_ready_go;
   logic               capture;
   logic               buf_load;
   logic               rf_we_g;
   logic [DATA_W-1:0]  raw_rdata;
   logic [DATA_W-1:0]  load_data;
   logic [DATA_W-1:0]  final_result;
   mem_wb_bus_t        wb_out;
   mem_id_bus_t        id_out;

   assign ex_in           = ex_mem_bus_t'(ex_to_mem_bus);
   assign mem_ready_go    = 1'b1;
   assign mem_allowin     = ~mem_valid_q | (mem_ready_go & wb_allowin);
   assign mem_to_wb_valid = mem_valid_q & mem_ready_go;
   assign capture         = ex_to_mem_valid & mem_allowin;
   // The SRAM word is only valid in the first cycle; keep it if WB refuses it then.
   assign buf_load        = mem_valid_q & first_cycle_q & payload_q.res_from_mem
                            & ~wb_allowin & ~buf_valid_q;

   // Next-state for handshake, payload and read-data buffer
   always_comb begin
      mem_valid_d   = mem_valid_q;
      payload_d     = payload_q;
      first_cycle_d = capture;
      buf_valid_d   = buf_valid_q;
      rdata_buf_d   = rdata_buf_q;
      if (mem_allowin) mem_valid_d = ex_to_mem_valid;
      if (capture) begin
         payload_d   = ex_in;
         buf_valid_d = 1'b0;
      end else if (buf_load) begin
         buf_valid_d = 1'b1;
      end
      if (buf_load) rdata_buf_d = data_sram_rdata;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid_q   <= 1'b0;
         first_cycle_q <= 1'b0;
         buf_valid_q   <= 1'b0;
         rdata_buf_q   <= '0;
         payload_q     <= '0;
      end else begin
         mem_valid_q   <= mem_valid_d;
         first_cycle_q <= first_cycle_d;
         buf_valid_q   <= buf_valid_d;
         rdata_buf_q   <= rdata_buf_d;
         payload_q     <= payload_d;
      end
   end

   assign raw_rdata = first_cycle_q ? data_sram_rdata : rdata_buf_q;

   mem_load_align u_align (
      .raw_rdata (raw_rdata),
      .addr_low  (payload_q.addr_low),
      .op_b      (payload_q.op_b),
      .op_h      (payload_q.op_h),
      .op_u      (payload_q.op_u),
      .data      (load_data)
   );

   assign final_result = payload_q.res_from_mem ? load_data : payload_q.alu_result;
   assign rf_we_g      = payload_q.rf_we & mem_valid_q;

   assign wb_out.pc           = payload_q.pc;
   assign wb_out.rf_we        = rf_we_g;
   assign wb_out.rf_waddr     = payload_q.rf_waddr;
   assign wb_out.final_result = final_result;
   assign wb_out.rkd_value    = payload_q.rkd_value;
   assign wb_out.csr_re       = payload_q.csr_re;
   assign wb_out.csr_we       = payload_q.csr_we;
   assign wb_out.csr_num      = payload_q.csr_num;
   assign mem_to_wb_bus       = wb_out;

   assign id_out.rf_we        = rf_we_g;
   assign id_out.rf_waddr     = payload_q.rf_waddr;
   assign id_out.final_result = final_result;
   assign mem_to_id_bus       = id_out;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

   logic         clk;
   logic         reset;
   logic         ex_to_mem_valid;
   logic [123:0] ex_to_mem_bus;
   logic         mem_allowin;
   logic [31:0]  data_sram_rdata;
   logic         wb_allowin;
   logic         mem_to_wb_valid;
   logic [117:0] mem_to_wb_bus;
   logic [37:0]  mem_to_id_bus;

   int errors;
   int checks;

   mem_stage dut (
      .clk             (clk),
      .reset           (reset),
      .ex_to_mem_valid (ex_to_mem_valid),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .mem_allowin     (mem_allowin),
      .data_sram_rdata (data_sram_rdata),
      .wb_allowin      (wb_allowin),
      .mem_to_wb_valid (mem_to_wb_valid),
      .mem_to_wb_bus   (mem_to_wb_bus),
      .mem_to_id_bus   (mem_to_id_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [123:0] mk_bus(input logic [31:0] pc, input logic rfm,
                                           input logic we, input logic [4:0] wa,
                                           input logic [31:0] alu, input logic [31:0] rkd,
                                           input logic [1:0] al, input logic b,
                                           input logic h, input logic u);
      return {pc, rfm, we, wa, alu, rkd, al, b, h, u, 1'b0, 1'b1, 14'h0123};
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ex_to_mem_valid = 1'b0;
      cycle();
      cycle();
      checks++;
      if (mem_to_wb_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b want 0", mem_to_wb_valid);
      end
      checks++;
      if (mem_allowin !== 1'b1) begin
         errors++; $display("FAIL reset_allowin: got %b want 1", mem_allowin);
      end
      checks++;
      if (mem_to_wb_bus !== 118'b0) begin
         errors++; $display("FAIL reset_wb_bus: got %h want 0", mem_to_wb_bus);
      end
      checks++;
      if (mem_to_id_bus !== 38'b0) begin
         errors++; $display("FAIL reset_id_bus: got %h want 0", mem_to_id_bus);
      end
      reset = 1'b0;
   endtask

   // Issue one load with wb_allowin=1 and check the aligned result in its first cycle
   task automatic load_once(input string name, input logic [1:0] al, input logic b,
                            input logic h, input logic u, input logic [31:0] rd,
                            input logic [31:0] exp);
      wb_allowin = 1'b1;
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus = mk_bus(32'h1C00_0100, 1'b1, 1'b1, 5'd4, 32'h0000_1003, 32'h0,
                             al, b, h, u);
      cycle();
      ex_to_mem_valid = 1'b0;
      data_sram_rdata = rd;
      #1;
      checks++;
      if (mem_to_wb_bus[79:48] !== exp || mem_to_wb_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s: result=%h valid=%b want %h valid=1", name,
                  mem_to_wb_bus[79:48], mem_to_wb_valid, exp);
      end
      checks++;
      if (mem_to_id_bus !== {1'b1, 5'd4, exp}) begin
         errors++; $display("FAIL %s_fwd: got %h want %h", name, mem_to_id_bus,
                            {1'b1, 5'd4, exp});
      end
   endtask

   task automatic test_load_byte();
      load_once("ldb_s", 2'd3, 1'b1, 1'b0, 1'b0, 32'h80FF_0011, 32'hFFFF_FF80);
      load_once("ldb_u", 2'd3, 1'b1, 1'b0, 1'b1, 32'h80FF_0011, 32'h0000_0080);
      load_once("ldb_a1", 2'd1, 1'b1, 1'b0, 1'b0, 32'h80FF_0011, 32'h0000_0000);
   endtask

   task automatic test_load_half();
      load_once("ldh_hi", 2'd2, 1'b0, 1'b1, 1'b0, 32'h1234_8001, 32'h0000_1234);
      load_once("ldh_lo", 2'd0, 1'b0, 1'b1, 1'b0, 32'h1234_8001, 32'hFFFF_8001);
      load_once("ldhu_lo", 2'd0, 1'b0, 1'b1, 1'b1, 32'h1234_8001, 32'h0000_8001);
      load_once("ldw_u", 2'd2, 1'b0, 1'b0, 1'b1, 32'h8765_4321, 32'h8765_4321);
   endtask

   task automatic test_stall_load();
      wb_allowin = 1'b1;
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus = mk_bus(32'h1C00_0200, 1'b1, 1'b1, 5'd7, 32'h0000_2000, 32'h0,
                             2'd0, 1'b0, 1'b0, 1'b0);
      cycle();
      wb_allowin = 1'b0;
      // A different instruction waits in EX; it must not be taken during the stall
      ex_to_mem_bus = mk_bus(32'h1C00_0204, 1'b0, 1'b1, 5'd9, 32'h0000_0999, 32'h0,
                             2'd0, 1'b0, 1'b0, 1'b0);
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (mem_to_wb_bus[79:48] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL stall_first: got %h want deadbeef", mem_to_wb_bus[79:48]);
      end
      for (int k = 0; k < 2; k++) begin
         cycle();
         data_sram_rdata = 32'h0;
         #1;
         checks++;
         if (mem_to_wb_bus[79:48] !== 32'hDEAD_BEEF || mem_to_wb_valid !== 1'b1 ||
             mem_allowin !== 1'b0 || mem_to_wb_bus[117:86] !== 32'h1C00_0200) begin
            errors++;
            $display("FAIL stall_hold%0d: result=%h valid=%b allowin=%b pc=%h want deadbeef 1 0 1c000200",
                     k, mem_to_wb_bus[79:48], mem_to_wb_valid, mem_allowin,
                     mem_to_wb_bus[117:86]);
         end
      end
      ex_to_mem_valid = 1'b0;
      wb_allowin = 1'b1;
      #1;
      checks++;
      if (mem_to_wb_bus[79:48] !== 32'hDEAD_BEEF || mem_allowin !== 1'b1) begin
         errors++; $display("FAIL stall_accept: result=%h allowin=%b want deadbeef 1",
                            mem_to_wb_bus[79:48], mem_allowin);
      end
      cycle();
      checks++;
      if (mem_to_wb_valid !== 1'b0 || mem_to_wb_bus[85] !== 1'b0 || mem_to_id_bus[37] !== 1'b0) begin
         errors++; $display("FAIL stall_drain: valid=%b wb_we=%b id_we=%b want 0 0 0",
                            mem_to_wb_valid, mem_to_wb_bus[85], mem_to_id_bus[37]);
      end
   endtask

   task automatic test_back_to_back();
      wb_allowin = 1'b1;
      data_sram_rdata = 32'hFFFF_FFFF;
      for (int i = 1; i <= 4; i++) begin
         ex_to_mem_valid = 1'b1;
         ex_to_mem_bus = mk_bus(32'h1C00_1000 + 32'(4 * i), 1'b0, 1'b1, 5'(i),
                                32'h0000_0111 * 32'(i), 32'hAAAA_0000 + 32'(i),
                                2'd0, 1'b0, 1'b0, 1'b0);
         cycle();
         checks++;
         if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus[79:48] !== 32'h0000_0111 * 32'(i) ||
             mem_to_wb_bus[117:86] !== 32'h1C00_1000 + 32'(4 * i) ||
             mem_to_wb_bus[47:16] !== 32'hAAAA_0000 + 32'(i)) begin
            errors++;
            $display("FAIL b2b_%0d: valid=%b result=%h pc=%h rkd=%h", i, mem_to_wb_valid,
                     mem_to_wb_bus[79:48], mem_to_wb_bus[117:86], mem_to_wb_bus[47:16]);
         end
      end
      ex_to_mem_valid = 1'b0;
      cycle();
      checks++;
      if (mem_to_wb_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_drain: got %b want 0", mem_to_wb_valid);
      end
   endtask

   task automatic test_reset_mid_stall();
      wb_allowin = 1'b0;
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus = mk_bus(32'h1C00_0300, 1'b1, 1'b1, 5'd11, 32'h0, 32'h0,
                             2'd0, 1'b0, 1'b0, 1'b0);
      cycle();
      ex_to_mem_valid = 1'b0;
      data_sram_rdata = 32'h55AA_55AA;
      cycle();
      data_sram_rdata = 32'h0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      #1;
      checks++;
      if (mem_to_wb_valid !== 1'b0 || mem_allowin !== 1'b1 || mem_to_id_bus[37] !== 1'b0) begin
         errors++; $display("FAIL rst_stall: valid=%b allowin=%b id_we=%b want 0 1 0",
                            mem_to_wb_valid, mem_allowin, mem_to_id_bus[37]);
      end
      wb_allowin = 1'b1;
      cycle();
      checks++;
      if (mem_to_wb_valid !== 1'b0 || mem_to_wb_bus !== 118'b0) begin
         errors++; $display("FAIL rst_stall_after: valid=%b bus=%h want 0 0",
                            mem_to_wb_valid, mem_to_wb_bus);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      ex_to_mem_valid = 1'b0;
      ex_to_mem_bus = '0;
      data_sram_rdata = '0;
      wb_allowin = 1'b1;
      test_reset();
      test_load_byte();
      test_load_half();
      test_stall_load();
      test_back_to_back();
      test_reset_mid_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
